// File: rtl/ib_fetch_aligner.sv
// Instruction-buffer fetch writer: splits aligned fetch blocks into RVC/RVI entries,
// carrying a block-straddling 32-bit instruction across blocks in a pending register.
module ib_fetch_aligner #(
  parameter int unsigned PC_WIDTH    = 64,
  parameter int unsigned WRITE_PORTS = 4,
  parameter int unsigned IB_DEPTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   Flush,
  input  logic                                   FetchValid,
  input  logic [PC_WIDTH-1:0]                    FetchPC,
  input  logic [16*WRITE_PORTS-1:0]              FetchData,
  input  logic                                   FetchFault,
  output logic                                   FetchReady,
  input  logic [$clog2(IB_DEPTH):0]              IBFreeCnt,
  output logic [WRITE_PORTS*(PC_WIDTH+34)-1:0]   IBDataIn,
  output logic [WRITE_PORTS-1:0]                 IBWriteEnable
);

  localparam int unsigned ENTRY_WIDTH = PC_WIDTH + 34;
  localparam int unsigned CNT_W       = $clog2(IB_DEPTH) + 1;
  localparam int unsigned HW_IDX      = $clog2(WRITE_PORTS);
  localparam int unsigned BLK_W       = 16 * WRITE_PORTS;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                            state;
  logic                              pend_v;
  logic [15:0]                       pend_half;
  logic [PC_WIDTH-1:0]               pend_pc;
  logic [WRITE_PORTS-1:0]            we_q;
  logic [WRITE_PORTS*ENTRY_WIDTH-1:0] data_q;

  logic [CNT_W:0]                    wr_cnt;
  logic [CNT_W:0]                    free_ext;
  logic                              space_ok;
  logic                              accept;

  logic [WRITE_PORTS-1:0]            nxt_we;
  logic [WRITE_PORTS*ENTRY_WIDTH-1:0] nxt_data;
  logic [ENTRY_WIDTH-1:0]            ent [WRITE_PORTS];
  logic                              nxt_pend_v;
  logic [15:0]                       nxt_pend_half;
  logic [PC_WIDTH-1:0]               nxt_pend_pc;
  logic [PC_WIDTH-1:0]               blk_pc;
  logic [BLK_W+15:0]                 data_ext;
  logic [15:0]                       hw;
  logic [15:0]                       hw_next;
  logic [HW_IDX-1:0]                 port;
  logic                              match;
  logic                              skip;
  int                                start_k;

  // Free-space test against the entries still being written this cycle
  always_comb begin
    wr_cnt = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      wr_cnt = wr_cnt + (CNT_W+1)'(we_q[p]);
    end
    free_ext = (CNT_W+1)'(IBFreeCnt);
    space_ok = (free_ext >= wr_cnt) && ((free_ext - wr_cnt) >= (CNT_W+1)'(WRITE_PORTS));
  end

  assign FetchReady    = rst && (state == RUN) && !Flush && space_ok;
  assign accept        = FetchValid && FetchReady;
  assign IBWriteEnable = we_q & {WRITE_PORTS{~Flush}};
  assign IBDataIn      = data_q;

  // Block scan: build the entries and the next pending state for an accepted block
  always_comb begin
    nxt_we        = '0;
    nxt_data      = '0;
    nxt_pend_v    = 1'b0;
    nxt_pend_half = pend_half;
    nxt_pend_pc   = pend_pc;
    port          = '0;
    skip          = 1'b0;
    hw            = '0;
    hw_next       = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      ent[p] = '0;
    end
    data_ext = {16'h0000, FetchData};
    blk_pc   = {FetchPC[PC_WIDTH-1:HW_IDX+1], (HW_IDX+1)'(0)};
    match    = pend_v && (FetchPC == pend_pc + PC_WIDTH'(2));
    start_k  = match ? 1 : int'(FetchPC[HW_IDX:1]);

    if (FetchFault) begin
      nxt_we[0] = 1'b1;
      ent[0]    = {1'b1, 1'b0, (match ? pend_pc : {FetchPC[PC_WIDTH-1:1], 1'b0}), 32'h0};
    end else begin
      if (match) begin
        nxt_we[0] = 1'b1;
        ent[0]    = {1'b0, 1'b0, pend_pc, FetchData[15:0], pend_half};
        port      = HW_IDX'(1);
      end
      for (int k = 0; k < WRITE_PORTS; k++) begin
        hw      = data_ext[16*k +: 16];
        hw_next = data_ext[16*(k+1) +: 16];
        if (skip) begin
          skip = 1'b0;
        end else if (k >= start_k) begin
          if (hw[1:0] != 2'b11) begin
            nxt_we[port] = 1'b1;
            ent[port]    = {1'b0, 1'b1, blk_pc + PC_WIDTH'(2*k), 16'h0000, hw};
            port         = port + HW_IDX'(1);
          end else if (k < WRITE_PORTS - 1) begin
            nxt_we[port] = 1'b1;
            ent[port]    = {1'b0, 1'b0, blk_pc + PC_WIDTH'(2*k), hw_next, hw};
            port         = port + HW_IDX'(1);
            skip         = 1'b1;
          end else begin
            nxt_pend_v    = 1'b1;
            nxt_pend_half = hw;
            nxt_pend_pc   = blk_pc + PC_WIDTH'(2*k);
          end
        end
      end
    end

    for (int p = 0; p < WRITE_PORTS; p++) begin
      nxt_data[p*ENTRY_WIDTH +: ENTRY_WIDTH] = ent[p];
    end
  end

  // State, pending and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_v    <= 1'b0;
      pend_half <= '0;
      pend_pc   <= '0;
      we_q      <= '0;
      data_q    <= '0;
    end else if (Flush) begin
      state  <= RUN;
      pend_v <= 1'b0;
      we_q   <= '0;
      data_q <= '0;
    end else if (accept) begin
      we_q      <= nxt_we;
      data_q    <= nxt_data;
      pend_v    <= nxt_pend_v;
      pend_half <= nxt_pend_half;
      pend_pc   <= nxt_pend_pc;
      if (FetchFault) begin
        state <= HALT;
      end
    end else begin
      we_q   <= '0;
      data_q <= '0;
    end
  end

endmodule

// File: tb/tb_ib_fetch_aligner.sv
// Scoreboard bench for ib_fetch_aligner: directed blocks push expected writes,
// a negedge monitor pops and compares whenever the IB write enables are active.
module tb_ib_fetch_aligner;

  logic          clk;
  logic          rst;
  logic          Flush;
  logic          FetchValid;
  logic [63:0]   FetchPC;
  logic [63:0]   FetchData;
  logic          FetchFault;
  logic          FetchReady;
  logic [4:0]    IBFreeCnt;
  logic [391:0]  IBDataIn;
  logic [3:0]    IBWriteEnable;

  typedef struct packed {
    logic [3:0]   we;
    logic [391:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  ib_fetch_aligner dut (
    .clk           (clk),
    .rst           (rst),
    .Flush         (Flush),
    .FetchValid    (FetchValid),
    .FetchPC       (FetchPC),
    .FetchData     (FetchData),
    .FetchFault    (FetchFault),
    .FetchReady    (FetchReady),
    .IBFreeCnt     (IBFreeCnt),
    .IBDataIn      (IBDataIn),
    .IBWriteEnable (IBWriteEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [97:0] ent(input logic f, input logic r, input logic [63:0] pc,
                                      input logic [31:0] ins);
    return {f, r, pc, ins};
  endfunction

  function automatic logic [63:0] blk(input logic [15:0] h0, input logic [15:0] h1,
                                      input logic [15:0] h2, input logic [15:0] h3);
    return {h3, h2, h1, h0};
  endfunction

  task automatic push(input logic [3:0] we, input logic [97:0] e0, input logic [97:0] e1,
                      input logic [97:0] e2, input logic [97:0] e3);
    exp_t e;
    e.we   = we;
    e.data = {e3, e2, e1, e0};
    exp_q.push_back(e);
  endtask

  // Present a block and hold it until accepted (bounded wait)
  task automatic send(input logic [63:0] pc, input logic [63:0] d, input logic f);
    int n;
    n          = 0;
    FetchValid = 1'b1;
    FetchPC    = pc;
    FetchData  = d;
    FetchFault = f;
    #1;
    while (!FetchReady && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!FetchReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: block pc %0h never accepted", pc);
    end else begin
      @(posedge clk);
      #1;
    end
    FetchValid = 1'b0;
    FetchFault = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && IBWriteEnable != 4'b0000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: we %b data %0h with nothing expected", IBWriteEnable, IBDataIn);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_we", 512'(IBWriteEnable), 512'(mon_e.we));
        chk("sb_data", 512'(IBDataIn), 512'(mon_e.data));
      end
    end
  end

  initial begin
    rst        = 1'b0;
    Flush      = 1'b0;
    FetchValid = 1'b0;
    FetchPC    = '0;
    FetchData  = '0;
    FetchFault = 1'b0;
    IBFreeCnt  = 5'd16;

    #12;
    chk("rst_we", 512'(IBWriteEnable), 512'(0));
    chk("rst_data", 512'(IBDataIn), 512'(0));
    chk("rst_ready", 512'(FetchReady), 512'(0));
    rst = 1'b1;
    #1;
    chk("release_ready", 512'(FetchReady), 512'(1));
    @(posedge clk);
    #1;

    // Four compressed halfwords
    push(4'b1111, ent(0, 1, 64'h1000, 32'h0001), ent(0, 1, 64'h1002, 32'h4501),
         ent(0, 1, 64'h1004, 32'h0505), ent(0, 1, 64'h1006, 32'h8082));
    send(64'h1000, blk(16'h0001, 16'h4501, 16'h0505, 16'h8082), 1'b0);

    // Backpressure with four writes in flight
    IBFreeCnt = 5'd8;
    #1;
    chk("bp_free8_ready", 512'(FetchReady), 512'(1));
    IBFreeCnt = 5'd7;
    #1;
    chk("bp_free7_ready", 512'(FetchReady), 512'(0));
    IBFreeCnt = 5'd16;
    @(posedge clk);
    #1;
    IBFreeCnt = 5'd3;
    #1;
    chk("bp_free3_ready", 512'(FetchReady), 512'(0));
    IBFreeCnt = 5'd4;
    #1;
    chk("bp_free4_ready", 512'(FetchReady), 512'(1));
    IBFreeCnt = 5'd16;

    // Straddling 32-bit instruction, back to back
    push(4'b0111, ent(0, 1, 64'h1000, 32'h0001), ent(0, 1, 64'h1002, 32'h4501),
         ent(0, 1, 64'h1004, 32'h0505), 98'h0);
    push(4'b1111, ent(0, 0, 64'h1006, 32'h0000_0297), ent(0, 1, 64'h100A, 32'h4501),
         ent(0, 1, 64'h100C, 32'h0505), ent(0, 1, 64'h100E, 32'h8082));
    send(64'h1000, blk(16'h0001, 16'h4501, 16'h0505, 16'h0297), 1'b0);
    send(64'h1008, blk(16'h0000, 16'h4501, 16'h0505, 16'h8082), 1'b0);

    // Mid-block start
    push(4'b0111, ent(0, 1, 64'h100A, 32'h4501), ent(0, 1, 64'h100C, 32'h0505),
         ent(0, 1, 64'h100E, 32'h8082), 98'h0);
    send(64'h100A, blk(16'hFFFF, 16'h4501, 16'h0505, 16'h8082), 1'b0);

    // Redirect drops pending
    push(4'b0111, ent(0, 1, 64'h1000, 32'h0001), ent(0, 1, 64'h1002, 32'h4501),
         ent(0, 1, 64'h1004, 32'h0505), 98'h0);
    push(4'b1111, ent(0, 1, 64'h2000, 32'h0001), ent(0, 1, 64'h2002, 32'h4501),
         ent(0, 1, 64'h2004, 32'h0505), ent(0, 1, 64'h2006, 32'h8082));
    send(64'h1000, blk(16'h0001, 16'h4501, 16'h0505, 16'h0297), 1'b0);
    send(64'h2000, blk(16'h0001, 16'h4501, 16'h0505, 16'h8082), 1'b0);

    // Fault then HALT until Flush
    push(4'b0001, ent(1, 0, 64'h2004, 32'h0), 98'h0, 98'h0, 98'h0);
    send(64'h2004, blk(16'h0001, 16'h4501, 16'h0505, 16'h8082), 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_ready", 512'(FetchReady), 512'(0));
    end
    @(posedge clk);
    #1;
    Flush = 1'b1;
    #1;
    chk("flush_ready_low", 512'(FetchReady), 512'(0));
    @(posedge clk);
    #1;
    Flush = 1'b0;
    #1;
    chk("post_flush_ready", 512'(FetchReady), 512'(1));

    // Flush in the cycle after a pending-creating block, with a matching block offered
    send(64'h1000, blk(16'h0001, 16'h4501, 16'h0505, 16'h0297), 1'b0);
    Flush      = 1'b1;
    FetchValid = 1'b1;
    FetchPC    = 64'h1008;
    FetchData  = blk(16'h0001, 16'h4501, 16'h0505, 16'h8082);
    #1;
    chk("flush_we_forced", 512'(IBWriteEnable), 512'(0));
    chk("flush_no_accept", 512'(FetchReady), 512'(0));
    @(posedge clk);
    #1;
    Flush      = 1'b0;
    FetchValid = 1'b0;

    // Stale pending must not be used after Flush
    push(4'b1111, ent(0, 1, 64'h1008, 32'h0001), ent(0, 1, 64'h100A, 32'h4501),
         ent(0, 1, 64'h100C, 32'h0505), ent(0, 1, 64'h100E, 32'h8082));
    send(64'h1008, blk(16'h0001, 16'h4501, 16'h0505, 16'h8082), 1'b0);
    push(4'b0011, ent(0, 1, 64'h100C, 32'h4501), ent(0, 1, 64'h100E, 32'h8082), 98'h0, 98'h0);
    send(64'h100C, blk(16'hFFFF, 16'hFFFF, 16'h4501, 16'h8082), 1'b0);

    // Asynchronous reset mid-stream
    @(posedge clk);
    #1;
    FetchValid = 1'b1;
    FetchPC    = 64'h3000;
    FetchData  = blk(16'h0001, 16'h4501, 16'h0505, 16'h8082);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_we", 512'(IBWriteEnable), 512'(0));
    chk("async_rst_data", 512'(IBDataIn), 512'(0));
    chk("async_rst_ready", 512'(FetchReady), 512'(0));
    FetchValid = 1'b0;
    #10;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 512'(exp_q.size()), 512'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ib_fetch_aligner.md
# ib_fetch_aligner

Fetch-side writer for the instruction buffer. It accepts aligned 64-bit fetch blocks from the I-cache/fetch stage and splits them into RV64C/RV64I instruction entries (16-bit or 32-bit). It carries a 32-bit instruction that straddles two blocks in an internal pending register. It drives the IB write ports (packed data bus, per-port write enable) one cycle after accepting a block, and throttles fetch using the IB free count.

## Interface
- PC_WIDTH, 64, width of instruction PC
- WRITE_PORTS, 4 (`FETCH_RATE_HW`), IB write ports; equals halfwords per fetch block
- IB_DEPTH, 16 (`IB_DEPTH`), IB capacity; sets IBFreeCnt width
- ENTRY_WIDTH, PC_WIDTH+34, IB entry = {fault, is_rvc, pc[PC_WIDTH-1:0], instr[31:0]} (instr in LSBs)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- Flush  in  1  synchronous pipeline flush/redirect
- FetchValid  in  1  fetch block valid
- FetchPC  in  PC_WIDTH  PC of first useful halfword; bits [2:1] give start offset, bit 0 = 0
- FetchData  in  16*WRITE_PORTS  block, halfword k at [16k+15:16k]
- FetchFault  in  1  access/page fault for this block
- FetchReady  out  1  block accepted when FetchValid & FetchReady
- IBFreeCnt  in  $clog2(IB_DEPTH)+1  IB free entries
- IBDataIn  out  WRITE_PORTS*ENTRY_WIDTH  entries, port p at [(p+1)*ENTRY_WIDTH-1:p*ENTRY_WIDTH]
- IBWriteEnable  out  WRITE_PORTS  per-port write enable, always packed from port 0

## Operation
- States: RUN and HALT. Reset state: RUN, pending empty, output register empty.
- Acceptance condition: FetchReady = RUN & ~Flush & (IBFreeCnt − popcount(IBWriteEnable) ≥ WRITE_PORTS).
  - The subtraction uses the current output register's write count.
  - The subtraction is done at width $clog2(IB_DEPTH)+2, with no underflow.
- Halfword k PC: {FetchPC[PC_WIDTH-1:3],3'b000} + 2k, modulo 2^PC_WIDTH. Scanning starts at k = FetchPC[2:1].
- If the pending register is valid and FetchPC ≠ pend_pc+2: discard the pending register and scan normally (redirect).
- If the pending register is valid and FetchPC = pend_pc+2 (offset is 0):
  - first entry: instr={hw0,pend_half}, pc=pend_pc, rvc=0.
  - clear the pending register and continue the scan at k=1.
- Scan, per halfword h:
  - h[1:0]≠2'b11: 16-bit entry, instr={16'b0,h}, rvc=1, advance 1.
  - otherwise, if a next halfword exists in the block: 32-bit entry, instr={h_next,h}, advance 2.
  - otherwise (h is the last halfword): latch pend_half=h and pend_pc; no entry.
- Entries fill ports 0,1,2,… in program order. The maximum is WRITE_PORTS, which is never exceeded.
- Fault block:
  - emit exactly one entry on port 0: fault=1, rvc=0, instr=0.
  - pc = pend_pc if a matching pending exists, else the halfword-offset PC.
  - clear the pending register and go to HALT.
- HALT: FetchReady=0 until Flush.
- Flush:
  - next state RUN; pending and output register cleared.
  - IBWriteEnable is forced to 0 combinationally during the Flush cycle.
  - Flush has priority over a simultaneous FetchValid; that block is not accepted.
- Unused ports: IBDataIn slice = 0.

## Timing
- Latency: a block accepted at edge N drives IBWriteEnable/IBDataIn during cycle N+1, valid for exactly one cycle. Outputs are registered.
- Throughput: one block per cycle when IB space allows.
- Output register: updated every cycle. It is loaded from the accepted block, or cleared to zero when no block is accepted. There is no hold.
- The pending register and state update at the same edge as acceptance.
- Reset values while rst=0:
  - IBWriteEnable=0, IBDataIn=0, FetchReady=0.
  - state=RUN; pending cleared.
- Reset release: FetchReady can assert in the first cycle after rst rises, given IBFreeCnt ≥ WRITE_PORTS.
- Reset mid-operation discards the output register and the pending register immediately (asynchronous).
- FetchValid with FetchReady=0: the block is ignored and state is unchanged. The source must hold FetchValid/FetchPC/FetchData stable.

## Test plan
- Four compressed halfwords:
  - Stimulus: FetchPC=0x1000, FetchData halfwords 0x0001,0x4501,0x0505,0x8082, IBFreeCnt=16.
  - Required next cycle: IBWriteEnable=4'b1111; PCs 0x1000/1002/1004/1006; rvc=1; instr=0x00000001 on port 0.
- Straddling 32-bit instruction:
  - Stimulus: block 0x1000 with hw3=0x0297, hw0–2 compressed; then block 0x1008 with hw0=0x0000, hw1–3 compressed.
  - Required: first write WE=4'b0111.
  - Required: second write port 0 = instr 0x00000297, pc 0x1006, rvc=0; WE=4'b1111.
- Mid-block start and redirect:
  - FetchPC=0x100A with three compressed halfwords → WE=4'b0111, PCs 0x100A/0x100C/0x100E.
  - Pending at pend_pc 0x1006, then FetchPC=0x2000 → pending dropped; port 0 pc=0x2000.
- Backpressure:
  - IBFreeCnt=3 → FetchReady=0.
  - Output register holding 4 writes with IBFreeCnt=8 → FetchReady=1; with IBFreeCnt=7 → FetchReady=0.
- Fault:
  - FetchFault=1, FetchPC=0x2004 → next cycle WE=4'b0001, fault=1, pc=0x2004.
  - FetchReady stays 0 for 10 cycles; Flush pulse → FetchReady=1 on the following cycle.
- Flush and reset:
  - Flush with pending valid and FetchValid=1 → no accept; IBWriteEnable=0 during Flush.
  - After Flush, a block at 0x100C does not use the stale pending.
  - rst=0 asserted mid-stream → all outputs 0 immediately.
